btn_autorepeat: RTL and testbench
=================================

// Module: btn_autorepeat
// PURPOSE
//  Consumes the debounced button levels and produces single-cycle edit pulses for the clock core
//  (hours = bit 1, minutes = bit 0): one pulse per press, then auto-repeat while the button is held.
//  Sits between the debouncer instances and the time/alarm edit inputs of the clock core.
//  One independent channel per button; the consumer increments its field once per pulse.
// PARAMETERS
//  N_BTNS         2           number of independent button channels
//  HOLD_CYCLES    50_000_000  cycles from first pulse to first repeat pulse (0.5 s @ 100 MHz); must be >= 2
//  REPEAT_CYCLES  20_000_000  cycles between repeat pulses (0.2 s @ 100 MHz); must be >= 2
// PORTS
//  clk        in   1       system clock (100 MHz)
//  reset      in   1       synchronous, active-high reset
//  btn_in     in   N_BTNS  debounced button levels, 1 = pressed; bit 1 hours, bit 0 minutes
//  pulse_out  out  N_BTNS  edit strobe, exactly 1 cycle wide per event
//  repeating  out  N_BTNS  1 while the channel is in auto-repeat (REPEAT state)
// BEHAVIOUR
//  - Per channel: state reg {IDLE, HOLD, REPEAT}; counter width $clog2(max(HOLD_CYCLES,REPEAT_CYCLES));
//    btn_q = btn_in delayed one cycle. All outputs registered.
//  - Reset: state=IDLE, counter=0, pulse_out=0, repeating=0, btn_q=1 (all ones). A button already held
//    when reset deasserts generates nothing until it has been seen low, then pressed again.
//  - IDLE: on btn_in=1 & btn_q=0 (rising edge sampled at edge k): pulse_out=1 in the cycle after edge k,
//    state->HOLD, counter=0. Otherwise pulse_out=0.
//  - HOLD: btn_in=1 -> counter++ each cycle; at counter==HOLD_CYCLES-1: pulse_out=1 next cycle,
//    state->REPEAT, counter=0. Spacing first->second pulse = exactly HOLD_CYCLES cycles.
//  - REPEAT: btn_in=1 -> counter++; at counter==REPEAT_CYCLES-1: pulse_out=1 next cycle, counter=0.
//    Spacing between repeat pulses = exactly REPEAT_CYCLES cycles, indefinitely (no saturation).
//  - Any state, btn_in=0: state->IDLE, counter=0, no pulse issued that cycle (release never pulses).
//    A release in the same cycle a terminal count would be reached suppresses that pulse.
//  - Re-press one cycle after release is a valid new rising edge -> new first pulse.
//  - repeating=1 exactly while state==REPEAT (registered with state).
//  - Channels fully independent: simultaneous presses produce simultaneous pulses; no priority,
//    no cross-channel lockout. Consumer handles both bits in one cycle.
//  - Reset asserted mid-hold/repeat: outputs 0 on the next cycle, channel stays silent until release+press.
//  - Counter never exceeds max(HOLD_CYCLES,REPEAT_CYCLES)-1; no wrap-around reachable.
//  - Elaboration-time check: HOLD_CYCLES<2 or REPEAT_CYCLES<2 -> $error.
// TESTING (bench params: N_BTNS=2, HOLD_CYCLES=8, REPEAT_CYCLES=4)
//  1 Tap: btn_in[0] high 3 cycles then low -> exactly one pulse_out[0], 1 cycle after rise; repeating[0]=0.
//  2 Hold 30 cycles on btn_in[1] -> pulses at t=1, 9, 13, 17, 21, 25, 29 rel. to rise; repeating[1]=1 from
//    cycle 9 until 1 cycle after release; no pulse on release.
//  3 Both buttons rise same cycle, held 12 -> identical pulse trains on bits 1 and 0 (t=1, 9).
//  4 btn_in[0]=1 throughout reset and after deassert -> no pulses; drop low 1 cycle, raise -> one pulse.
//  5 Reset asserted at cycle 10 of a hold -> pulse_out=0, repeating=0 next cycle; stays 0 while held.
//  6 Release exactly on terminal-count cycle of HOLD (btn low at counter==7) -> no second pulse, IDLE;
//    re-press next cycle -> new first pulse 1 cycle later.

Source files
------------

// File: rtl/btn_autorepeat.sv
// Button auto-repeat: turns debounced button levels into single-cycle edit
// pulses. One pulse on press, a first repeat after HOLD_CYCLES, then a repeat
// every REPEAT_CYCLES while the button stays held. Channels are independent.
module btn_autorepeat #(
  parameter int N_BTNS        = 2,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 20_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_BTNS-1:0] btn_in,
  output logic [N_BTNS-1:0] pulse_out,
  output logic [N_BTNS-1:0] repeating
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_REPEAT
  } state_t;

  // A one-cycle interval would make the counter compare degenerate.
  if (HOLD_CYCLES < 2) begin : g_bad_hold
    $error("btn_autorepeat: HOLD_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("btn_autorepeat: REPEAT_CYCLES must be >= 2");
  end

  for (genvar i = 0; i < N_BTNS; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_q;
    logic             pulse_q, pulse_d;
    logic             rep_q, rep_d;

    // Next-state, counter and pulse decision for this channel.
    always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      if (!btn_in[i]) begin
        // Release always returns to idle and never pulses, even on a terminal count.
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            // btn_q resets high, so a button held through reset is not a new press.
            if (!btn_q) begin
              pulse_d = 1'b1;
              state_d = S_HOLD;
              cnt_d   = '0;
            end
          end
          S_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
              pulse_d = 1'b1;
              state_d = S_REPEAT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          S_REPEAT: begin
            if (cnt_q == REPEAT_LAST) begin
              pulse_d = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
      rep_d = (state_d == S_REPEAT);
    end

    // Channel registers, with synchronous reset to a silent idle state.
    always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (reset) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        btn_q   <= 1'b1;
        pulse_q <= 1'b0;
        rep_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        btn_q   <= btn_in[i];
        pulse_q <= pulse_d;
        rep_q   <= rep_d;
      end
    end

    assign pulse_out[i] = pulse_q;
    assign repeating[i] = rep_q;
  end

endmodule

// File: tb/tb_btn_autorepeat.sv
// Bench for btn_autorepeat: directed button sequences, a held-time model that
// predicts every pulse and the repeat flag per cycle, and literal pulse trains.
module tb_btn_autorepeat;

  localparam int N = 2;
  localparam int H = 8;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_in;
  logic [N-1:0] pulse_out;
  logic [N-1:0] repeating;

  btn_autorepeat #(
    .N_BTNS       (N),
    .HOLD_CYCLES  (H),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_in   (btn_in),
    .pulse_out(pulse_out),
    .repeating(repeating)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rise_cyc = 0;
  bit model_valid = 1'b0;

  // Model state: per channel, whether a valid press is active and how long it has been held.
  bit       m_prev   [N];
  bit       m_active [N];
  int       m_len    [N];
  bit       exp_pulse[N];
  bit       exp_rep  [N];

  // Pulse logs (cycle offsets from rise_cyc) from the model and from the DUT.
  int mq0[$];
  int mq1[$];
  int dq0[$];
  int dq1[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: a press is a sampled low->high; pulses at held length 0, H, H+R, H+2R, ...
  always @(posedge clk) begin
    cyc++;
    for (int ch = 0; ch < N; ch++) begin
      if (reset) begin
        m_prev[ch]    = 1'b1;
        m_active[ch]  = 1'b0;
        m_len[ch]     = 0;
        exp_pulse[ch] = 1'b0;
      end else begin
        if (btn_in[ch] && !m_prev[ch]) begin
          m_active[ch]  = 1'b1;
          m_len[ch]     = 0;
          exp_pulse[ch] = 1'b1;
        end else if (btn_in[ch] && m_active[ch]) begin
          m_len[ch]     = m_len[ch] + 1;
          exp_pulse[ch] = (m_len[ch] == H) || (m_len[ch] > H && ((m_len[ch] - H) % R) == 0);
        end else begin
          if (!btn_in[ch]) m_active[ch] = 1'b0;
          exp_pulse[ch] = 1'b0;
        end
        m_prev[ch] = btn_in[ch];
      end
      exp_rep[ch] = m_active[ch] && (m_len[ch] >= H);
    end
    model_valid = 1'b1;
  end

  // Per-cycle comparison of the DUT against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      for (int ch = 0; ch < N; ch++) begin
        check($sformatf("pulse_out[%0d]", ch), 32'(pulse_out[ch]), 32'(exp_pulse[ch]));
        check($sformatf("repeating[%0d]", ch), 32'(repeating[ch]), 32'(exp_rep[ch]));
      end
      if (exp_pulse[0]) mq0.push_back(cyc - rise_cyc);
      if (exp_pulse[1]) mq1.push_back(cyc - rise_cyc);
      if (pulse_out[0] === 1'b1) dq0.push_back(cyc - rise_cyc);
      if (pulse_out[1] === 1'b1) dq1.push_back(cyc - rise_cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    mq0.delete();
    mq1.delete();
    dq0.delete();
    dq1.delete();
    rise_cyc = cyc;
  endtask

  // Compare both the model log and the DUT log against a hand-computed pulse train.
  task automatic check_train(input string nm, input int ch, input int exp[8], input int n);
    int mq[$];
    int dq[$];
    if (ch == 0) begin
      mq = mq0;
      dq = dq0;
    end else begin
      mq = mq1;
      dq = dq1;
    end
    check({nm, "_model_cnt"}, 32'(mq.size()), 32'(n));
    check({nm, "_dut_cnt"}, 32'(dq.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_model[%0d]", nm, i), (i < mq.size()) ? 32'(mq[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
      check($sformatf("%s_dut[%0d]", nm, i), (i < dq.size()) ? 32'(dq[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
    end
  endtask

  initial begin
    reset  = 1'b1;
    btn_in = '0;
    step(3);
    check("reset_pulse", 32'(pulse_out), 32'd0);
    check("reset_rep", 32'(repeating), 32'd0);
    reset = 1'b0;
    step(2);

    // 1: tap on minutes
    clear_logs();
    btn_in[0] = 1'b1;
    step(3);
    btn_in[0] = 1'b0;
    step(6);
    check_train("tap", 0, '{1, 0, 0, 0, 0, 0, 0, 0}, 1);
    check_train("tap_other", 1, '{0, 0, 0, 0, 0, 0, 0, 0}, 0);

    // 2: long hold on hours
    clear_logs();
    btn_in[1] = 1'b1;
    step(8);
    check("hold_rep_t8_model", 32'(exp_rep[1]), 32'd0);
    check("hold_rep_t8_dut", 32'(repeating[1]), 32'd0);
    step(1);
    check("hold_rep_t9_model", 32'(exp_rep[1]), 32'd1);
    check("hold_rep_t9_dut", 32'(repeating[1]), 32'd1);
    step(21);
    check("hold_rep_t30_dut", 32'(repeating[1]), 32'd1);
    btn_in[1] = 1'b0;
    step(1);
    check("hold_rep_t31_dut", 32'(repeating[1]), 32'd0);
    step(5);
    check_train("hold", 1, '{1, 9, 13, 17, 21, 25, 29, 0}, 7);

    // 3: both buttons together
    clear_logs();
    btn_in = 2'b11;
    step(12);
    btn_in = 2'b00;
    step(5);
    check_train("both0", 0, '{1, 9, 0, 0, 0, 0, 0, 0}, 2);
    check_train("both1", 1, '{1, 9, 0, 0, 0, 0, 0, 0}, 2);

    // 4: button held through reset is ignored until released and pressed again
    reset     = 1'b1;
    btn_in[0] = 1'b1;
    step(3);
    reset = 1'b0;
    clear_logs();
    step(20);
    check_train("held_reset", 0, '{0, 0, 0, 0, 0, 0, 0, 0}, 0);
    btn_in[0] = 1'b0;
    step(1);
    clear_logs();
    btn_in[0] = 1'b1;
    step(4);
    btn_in[0] = 1'b0;
    step(4);
    check_train("repress", 0, '{1, 0, 0, 0, 0, 0, 0, 0}, 1);

    // 5: reset mid-repeat silences the channel while still held
    clear_logs();
    btn_in[1] = 1'b1;
    step(10);
    check("mid_rep_t10_dut", 32'(repeating[1]), 32'd1);
    reset = 1'b1;
    step(1);
    check("mid_reset_pulse", 32'(pulse_out[1]), 32'd0);
    check("mid_reset_rep", 32'(repeating[1]), 32'd0);
    step(1);
    reset = 1'b0;
    step(15);
    check("mid_after_rep", 32'(repeating[1]), 32'd0);
    btn_in[1] = 1'b0;
    step(3);
    check_train("mid_reset", 1, '{1, 9, 0, 0, 0, 0, 0, 0}, 2);

    // 6: release on the hold terminal-count cycle, then immediate re-press
    clear_logs();
    btn_in[0] = 1'b1;
    step(8);
    btn_in[0] = 1'b0;
    step(1);
    btn_in[0] = 1'b1;
    step(3);
    btn_in[0] = 1'b0;
    step(4);
    check_train("term_release", 0, '{1, 10, 0, 0, 0, 0, 0, 0}, 2);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
